ysyx_23060072_pipe_ctrl: RTL and testbench
==========================================

YSYX_23060072_PIPE_CTRL -- requirements
Module: ysyx_23060072_pipe_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the stall-cycle counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 id_rs1_addr_i / id_rs2_addr_i  input  5 each  source register addresses decoded in ID.
REQ-005 id_has_rs1_i / id_has_rs2_i  input  1 each  ID instruction reads rs1 / rs2.
REQ-006 ex_load_flag_i  input  1  instruction in EX is a load.
REQ-007 ex_wb_reg_waddr_i  input  5  destination register of the EX instruction.
REQ-008 jump_flag_i  input  1  EX resolved a taken branch/jump this cycle.
REQ-009 trap_flag_i  input  1  EX redirects to a trap/mret target this cycle.
REQ-010 if_valid_i  input  1  IF presents a valid fetched instruction.
REQ-011 lsu_req_i / lsu_done_i  input  1 each  memory access issued / completed.
REQ-012 multdiv_start_i / multdiv_done_i  input  1 each  mult/div started / result ready.
REQ-013 if_hold_flag_o, id_hold_flag_o, ex_hold_flag_o  output  1 each  freeze the IF, IF/ID, ID/EX registers.
REQ-014 clean_flag_o  output  1  load a bubble into ID/EX.
REQ-015 if_flush_o  output  1  invalidate the IF/ID register.
REQ-016 state_o  output  3  current FSM state encoding.
REQ-017 stall_cnt_o  output  CNT_W  saturating count of stalled cycles.

Function
REQ-018 FSM states SHALL be RUN=0, MEM_WAIT=1, MD_WAIT=2, REFILL=3; other encodings SHALL return to RUN next cycle.
REQ-019 In RUN, events SHALL be prioritised: trap > jump > lsu_req > multdiv_start > load-use; only the highest applies.
REQ-020 Redirect (trap or jump) in RUN: same cycle if_flush_o=1, clean_flag_o=1, no holds; next state REFILL.
REQ-021 REFILL: clean_flag_o=1 and if_flush_o=1 each cycle while if_valid_i=0; if_valid_i=1 SHALL drop both in that cycle and move to RUN.
REQ-022 lsu_req_i in RUN with lsu_done_i=0: all three holds=1 that cycle, next state MEM_WAIT; with lsu_done_i=1 same cycle: no stall, stay RUN.
REQ-023 MEM_WAIT: all holds=1 while lsu_done_i=0; lsu_done_i=1 SHALL release all holds in that cycle and return to RUN.
REQ-024 MD_WAIT behaves as MEM_WAIT with multdiv_start_i/multdiv_done_i, including the same-cycle-done case.
REQ-025 Load-use hazard = ex_load_flag_i & ex_wb_reg_waddr_i!=0 & ((id_has_rs1_i & rs1==waddr) | (id_has_rs2_i & rs2==waddr)); in RUN: if_hold=id_hold=1, clean_flag=1, ex_hold=0, one cycle, stay RUN.
REQ-026 jump_flag_i, trap_flag_i, load-use SHALL be ignored outside RUN; lsu/multdiv starts SHALL be ignored outside RUN.
REQ-027 Hold/clean/flush outputs SHALL be combinational from state and inputs; state_o and stall_cnt_o registered.
REQ-028 stall_cnt SHALL increment by 1 on every cycle with any hold or clean_flag_o asserted, saturating at 2^CNT_W-1.
REQ-029 When no rule applies, all hold/clean/flush outputs SHALL be 0.

Reset
REQ-030 rst_n low SHALL asynchronously force state RUN and stall_cnt 0, and SHALL force all hold/clean/flush outputs to 0 while low.
REQ-031 Reset asserted in MEM_WAIT, MD_WAIT or REFILL SHALL abandon the wait; after release, the FSM evaluates RUN rules on the first edge.

Verification
REQ-032 Load-use: ex_load=1, waddr=5, id_has_rs1=1, rs1=5 -> one cycle if_hold=id_hold=clean=1, ex_hold=0; stall_cnt 0->1.
REQ-033 Load to x0: waddr=0, rs1=0 -> no hold, no clean, stall_cnt unchanged.
REQ-034 lsu_req at t0, lsu_done at t3 -> holds=1 at t0..t2, 0 at t3; state_o 1 during t1..t3, 0 at t4; stall_cnt +3.
REQ-035 jump and lsu_req same cycle, if_valid low 2 cycles -> flush/clean for 3 cycles, state REFILL, no MEM_WAIT entry.
REQ-036 rst_n low mid MD_WAIT -> immediately all outputs 0, state_o=0, stall_cnt_o=0; done pulse after release ignored.
REQ-037 CNT_W=4, 20 consecutive stall cycles -> stall_cnt_o saturates at 15.

Source files
------------

// File: rtl/ysyx_23060072_pipe_ctrl_if.sv
// ============================================================================
// Module      : ysyx_23060072_pipe_ctrl_if
// Description : Hazard/stall handshake bundle between the pipeline and its
//               control FSM (pipeline = master, controller = slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_23060072_pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1_addr_i;
    logic [4:0]       id_rs2_addr_i;
    logic             id_has_rs1_i;
    logic             id_has_rs2_i;
    logic             ex_load_flag_i;
    logic [4:0]       ex_wb_reg_waddr_i;
    logic             jump_flag_i;
    logic             trap_flag_i;
    logic             if_valid_i;
    logic             lsu_req_i;
    logic             lsu_done_i;
    logic             multdiv_start_i;
    logic             multdiv_done_i;
    logic             if_hold_flag_o;
    logic             id_hold_flag_o;
    logic             ex_hold_flag_o;
    logic             clean_flag_o;
    logic             if_flush_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_has_rs1_i, id_has_rs2_i,
               ex_load_flag_i, ex_wb_reg_waddr_i, jump_flag_i, trap_flag_i,
               if_valid_i, lsu_req_i, lsu_done_i, multdiv_start_i, multdiv_done_i,
        input  if_hold_flag_o, id_hold_flag_o, ex_hold_flag_o, clean_flag_o,
               if_flush_o, state_o, stall_cnt_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_has_rs1_i, id_has_rs2_i,
               ex_load_flag_i, ex_wb_reg_waddr_i, jump_flag_i, trap_flag_i,
               if_valid_i, lsu_req_i, lsu_done_i, multdiv_start_i, multdiv_done_i,
        output if_hold_flag_o, id_hold_flag_o, ex_hold_flag_o, clean_flag_o,
               if_flush_o, state_o, stall_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_23060072_pipe_ctrl.sv
// ============================================================================
// Module      : ysyx_23060072_pipe_ctrl
// Description : Pipeline hazard controller: redirect flush/refill, memory and
//               mult/div wait stalls, load-use bubbles, stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060072_pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    ysyx_23060072_pipe_ctrl_if.slave     bus
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_MD_WAIT  = 3'd2,
        ST_REFILL   = 3'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_if_hold;
    logic w_id_hold;
    logic w_ex_hold;
    logic w_clean;
    logic w_flush;
    logic w_load_use;
    logic w_any_stall;

    // A load writing x0 never creates a real dependency.
    assign w_load_use = bus.ex_load_flag_i && (bus.ex_wb_reg_waddr_i != 5'd0) &&
                        ((bus.id_has_rs1_i && (bus.id_rs1_addr_i == bus.ex_wb_reg_waddr_i)) ||
                         (bus.id_has_rs2_i && (bus.id_rs2_addr_i == bus.ex_wb_reg_waddr_i)));

    always_comb begin
        w_if_hold   = 1'b0;
        w_id_hold   = 1'b0;
        w_ex_hold   = 1'b0;
        w_clean     = 1'b0;
        w_flush     = 1'b0;
        w_state_nxt = ST_RUN;
        case (r_state)
            ST_RUN: begin
                if (bus.trap_flag_i || bus.jump_flag_i) begin
                    w_flush     = 1'b1;
                    w_clean     = 1'b1;
                    w_state_nxt = ST_REFILL;
                end else if (bus.lsu_req_i) begin
                    if (!bus.lsu_done_i) begin
                        w_if_hold   = 1'b1;
                        w_id_hold   = 1'b1;
                        w_ex_hold   = 1'b1;
                        w_state_nxt = ST_MEM_WAIT;
                    end
                end else if (bus.multdiv_start_i) begin
                    if (!bus.multdiv_done_i) begin
                        w_if_hold   = 1'b1;
                        w_id_hold   = 1'b1;
                        w_ex_hold   = 1'b1;
                        w_state_nxt = ST_MD_WAIT;
                    end
                end else if (w_load_use) begin
                    w_if_hold = 1'b1;
                    w_id_hold = 1'b1;
                    w_clean   = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!bus.lsu_done_i) begin
                    w_if_hold   = 1'b1;
                    w_id_hold   = 1'b1;
                    w_ex_hold   = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                end
            end
            ST_MD_WAIT: begin
                if (!bus.multdiv_done_i) begin
                    w_if_hold   = 1'b1;
                    w_id_hold   = 1'b1;
                    w_ex_hold   = 1'b1;
                    w_state_nxt = ST_MD_WAIT;
                end
            end
            ST_REFILL: begin
                if (!bus.if_valid_i) begin
                    w_flush     = 1'b1;
                    w_clean     = 1'b1;
                    w_state_nxt = ST_REFILL;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign w_any_stall = w_if_hold || w_id_hold || w_ex_hold || w_clean;

    // Control outputs are squashed for the whole time reset is held low.
    assign bus.if_hold_flag_o = w_if_hold & rst_n;
    assign bus.id_hold_flag_o = w_id_hold & rst_n;
    assign bus.ex_hold_flag_o = w_ex_hold & rst_n;
    assign bus.clean_flag_o   = w_clean   & rst_n;
    assign bus.if_flush_o     = w_flush   & rst_n;
    assign bus.state_o        = r_state;
    assign bus.stall_cnt_o    = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_any_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060072_pipe_ctrl.sv
// ============================================================================
// Module      : tb_ysyx_23060072_pipe_ctrl
// Description : Directed plus random stimulus for the pipeline controller,
//               checked against a behavioural model with immediate asserts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060072_pipe_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_23060072_pipe_ctrl_if #(.CNT_W(16)) bus ();
    ysyx_23060072_pipe_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus4.id_rs1_addr_i     = bus.id_rs1_addr_i;
    assign bus4.id_rs2_addr_i     = bus.id_rs2_addr_i;
    assign bus4.id_has_rs1_i      = bus.id_has_rs1_i;
    assign bus4.id_has_rs2_i      = bus.id_has_rs2_i;
    assign bus4.ex_load_flag_i    = bus.ex_load_flag_i;
    assign bus4.ex_wb_reg_waddr_i = bus.ex_wb_reg_waddr_i;
    assign bus4.jump_flag_i       = bus.jump_flag_i;
    assign bus4.trap_flag_i       = bus.trap_flag_i;
    assign bus4.if_valid_i        = bus.if_valid_i;
    assign bus4.lsu_req_i         = bus.lsu_req_i;
    assign bus4.lsu_done_i        = bus.lsu_done_i;
    assign bus4.multdiv_start_i   = bus.multdiv_start_i;
    assign bus4.multdiv_done_i    = bus.multdiv_done_i;

    ysyx_23060072_pipe_ctrl #(.CNT_W(16)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    ysyx_23060072_pipe_ctrl #(.CNT_W(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: what the pipeline is waiting on, and stall totals.
    bit  m_mem, m_md, m_refill;
    bit  n_mem, n_md, n_refill;
    int  m_cnt16, m_cnt4;
    bit  e_if, e_id, e_ex, e_clean, e_flush, e_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        bus.id_rs1_addr_i = 5'd0;  bus.id_rs2_addr_i = 5'd0;
        bus.id_has_rs1_i = 1'b0;   bus.id_has_rs2_i = 1'b0;
        bus.ex_load_flag_i = 1'b0; bus.ex_wb_reg_waddr_i = 5'd0;
        bus.jump_flag_i = 1'b0;    bus.trap_flag_i = 1'b0;
        bus.if_valid_i = 1'b0;     bus.lsu_req_i = 1'b0;
        bus.lsu_done_i = 1'b0;     bus.multdiv_start_i = 1'b0;
        bus.multdiv_done_i = 1'b0;
    endtask

    task automatic model_eval();
        bit hazard;
        {e_if, e_id, e_ex, e_clean, e_flush} = 5'b0;
        n_mem = m_mem; n_md = m_md; n_refill = m_refill;
        hazard = bus.ex_load_flag_i && bus.ex_wb_reg_waddr_i != 0 &&
                 ((bus.id_has_rs1_i && bus.id_rs1_addr_i == bus.ex_wb_reg_waddr_i) ||
                  (bus.id_has_rs2_i && bus.id_rs2_addr_i == bus.ex_wb_reg_waddr_i));
        if (m_refill) begin
            if (bus.if_valid_i) n_refill = 0;
            else begin e_flush = 1; e_clean = 1; end
        end else if (m_mem) begin
            if (bus.lsu_done_i) n_mem = 0;
            else begin e_if = 1; e_id = 1; e_ex = 1; end
        end else if (m_md) begin
            if (bus.multdiv_done_i) n_md = 0;
            else begin e_if = 1; e_id = 1; e_ex = 1; end
        end else if (bus.trap_flag_i || bus.jump_flag_i) begin
            e_flush = 1; e_clean = 1; n_refill = 1;
        end else if (bus.lsu_req_i) begin
            if (!bus.lsu_done_i) begin e_if = 1; e_id = 1; e_ex = 1; n_mem = 1; end
        end else if (bus.multdiv_start_i) begin
            if (!bus.multdiv_done_i) begin e_if = 1; e_id = 1; e_ex = 1; n_md = 1; end
        end else if (hazard) begin
            e_if = 1; e_id = 1; e_clean = 1;
        end
        e_stall = e_if | e_id | e_ex | e_clean;
    endtask

    function automatic int exp_state();
        return m_refill ? 3 : m_mem ? 1 : m_md ? 2 : 0;
    endfunction

    // Inputs are already set; check combinational outputs, clock, check registers.
    task automatic step(input string tag);
        #2;
        model_eval();
        chk({tag, ".if_hold"}, 32'(bus.if_hold_flag_o), 32'(e_if));
        chk({tag, ".id_hold"}, 32'(bus.id_hold_flag_o), 32'(e_id));
        chk({tag, ".ex_hold"}, 32'(bus.ex_hold_flag_o), 32'(e_ex));
        chk({tag, ".clean"},   32'(bus.clean_flag_o),   32'(e_clean));
        chk({tag, ".flush"},   32'(bus.if_flush_o),     32'(e_flush));
        chk({tag, ".hold4"},   32'(bus4.if_hold_flag_o), 32'(e_if));
        @(posedge clk);
        #1;
        m_mem = n_mem; m_md = n_md; m_refill = n_refill;
        if (e_stall) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        chk({tag, ".state"},  32'(bus.state_o),      32'(exp_state()));
        chk({tag, ".cnt16"},  32'(bus.stall_cnt_o),  32'(m_cnt16));
        chk({tag, ".cnt4"},   32'(bus4.stall_cnt_o), 32'(m_cnt4));
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, ".if_hold"}, 32'(bus.if_hold_flag_o), 0);
        chk({tag, ".id_hold"}, 32'(bus.id_hold_flag_o), 0);
        chk({tag, ".ex_hold"}, 32'(bus.ex_hold_flag_o), 0);
        chk({tag, ".clean"},   32'(bus.clean_flag_o),   0);
        chk({tag, ".flush"},   32'(bus.if_flush_o),     0);
        chk({tag, ".state"},   32'(bus.state_o),        0);
        chk({tag, ".cnt16"},   32'(bus.stall_cnt_o),    0);
        chk({tag, ".cnt4"},    32'(bus4.stall_cnt_o),   0);
    endtask

    initial begin
        int c0;
        clr_in();
        m_mem = 0; m_md = 0; m_refill = 0; m_cnt16 = 0; m_cnt4 = 0;

        // Reset: outputs stay low even with a redirect request present.
        bus.jump_flag_i = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check_reset_outs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_in();

        // Load-use on rs1.
        bus.ex_load_flag_i = 1; bus.ex_wb_reg_waddr_i = 5'd5;
        bus.id_has_rs1_i = 1;   bus.id_rs1_addr_i = 5'd5;
        step("loaduse");
        chk("loaduse.cnt_is_1", 32'(bus.stall_cnt_o), 1);
        clr_in();
        step("idle");

        // Load to x0 is not a hazard.
        bus.ex_load_flag_i = 1; bus.ex_wb_reg_waddr_i = 5'd0;
        bus.id_has_rs1_i = 1;   bus.id_rs1_addr_i = 5'd0;
        step("x0");
        chk("x0.cnt_is_1", 32'(bus.stall_cnt_o), 1);
        clr_in();

        // Memory wait: request at t0, done at t3.
        c0 = m_cnt16;
        bus.lsu_req_i = 1; step("mem.t0");
        chk("mem.t1.state", 32'(bus.state_o), 1);
        bus.lsu_req_i = 0; step("mem.t1");
        step("mem.t2");
        chk("mem.t3.state", 32'(bus.state_o), 1);
        bus.lsu_done_i = 1; step("mem.t3");
        bus.lsu_done_i = 0;
        chk("mem.t4.state", 32'(bus.state_o), 0);
        chk("mem.cnt_plus3", 32'(bus.stall_cnt_o), 32'(c0 + 3));

        // Jump beats lsu_req; fetch stays invalid for two cycles.
        bus.jump_flag_i = 1; bus.lsu_req_i = 1; step("redir.t0");
        chk("redir.state", 32'(bus.state_o), 3);
        bus.jump_flag_i = 0; bus.lsu_req_i = 0;
        step("redir.t1");
        step("redir.t2");
        bus.if_valid_i = 1; step("redir.t3");
        bus.if_valid_i = 0;

        // Async reset in the middle of a mult/div wait.
        bus.multdiv_start_i = 1; step("md.t0");
        bus.multdiv_start_i = 0; step("md.t1");
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outs("md.rst");
        m_mem = 0; m_md = 0; m_refill = 0; m_cnt16 = 0; m_cnt4 = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.multdiv_done_i = 1; step("md.after");
        bus.multdiv_done_i = 0;

        // 20 back-to-back load-use stalls saturate the 4-bit counter.
        bus.ex_load_flag_i = 1; bus.ex_wb_reg_waddr_i = 5'd9;
        bus.id_has_rs2_i = 1;   bus.id_rs2_addr_i = 5'd9;
        for (int i = 0; i < 20; i++) step("sat");
        chk("sat.cnt4_is_15", 32'(bus4.stall_cnt_o), 15);
        chk("sat.cnt16_is_20", 32'(bus.stall_cnt_o), 20);
        clr_in();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.id_rs1_addr_i     = 5'($urandom_range(0, 3));
            bus.id_rs2_addr_i     = 5'($urandom_range(0, 3));
            bus.id_has_rs1_i      = 1'($urandom_range(0, 1));
            bus.id_has_rs2_i      = 1'($urandom_range(0, 1));
            bus.ex_load_flag_i    = 1'($urandom_range(0, 1));
            bus.ex_wb_reg_waddr_i = 5'($urandom_range(0, 3));
            bus.jump_flag_i       = ($urandom_range(0, 7) == 0);
            bus.trap_flag_i       = ($urandom_range(0, 15) == 0);
            bus.if_valid_i        = ($urandom_range(0, 2) == 0);
            bus.lsu_req_i         = ($urandom_range(0, 5) == 0);
            bus.lsu_done_i        = ($urandom_range(0, 2) == 0);
            bus.multdiv_start_i   = ($urandom_range(0, 5) == 0);
            bus.multdiv_done_i    = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
